input_debounce_ctrl: RTL



---
 rtl/input_debounce_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/input_debounce_ctrl.sv
// -----------------------------------------------------------------------------
// input_debounce_ctrl
//
// Front end of the memory-mapped switch/button input peripheral. Synchronizes
// the raw switches and buttons, debounces the buttons, latches press events in
// a sticky pending register and raises a maskable level interrupt. Reads are a
// zero-latency combinational mux on addr; writes configure the mask and clear
// events (write-one-to-clear).
//
// Optional feature macro: INPUT_RELEASE_EVENT_EN
//   When defined, button releases (stable 1->0) are latched in a W1C release
//   register at 0x1C and also contribute to irq. When undefined, no release
//   flops exist and 0x1C reads 0.
//
// Ports:
//   clk     in   1   system clock, all state on the rising edge
//   rst     in   1   synchronous active-high reset
//   addr    in   8   peripheral byte address, full 8-bit decode
//   we      in   1   write strobe for addr
//   wdata   in  32   write data
//   io_sw   in  32   raw asynchronous switches
//   io_btn  in   4   raw asynchronous buttons, active-high
//   rdata   out 32   combinational read data for addr
//   irq     out  1   registered level interrupt
//
// Register map (unused bits read 0, unmapped addresses read 0):
//   0x00  sw_sync[31:0]  RO
//   0x10  stable[3:0]    RO
//   0x14  pend[3:0]      W1C
//   0x18  mask[3:0]      RW
//   0x1C  rel[3:0]       W1C (only with INPUT_RELEASE_EVENT_EN)
// -----------------------------------------------------------------------------
module input_debounce_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   input  logic [31:0] io_sw,
   input  logic [3:0]  io_btn,
   output logic [31:0] rdata,
   output logic        irq
);

   // Counter width is derived from the debounce length and is not overridable.
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned NBTN  = 4;

   // Terminal count: the stable value flips on the edge where the counter
   // has already seen DEBOUNCE_CYCLES-1 differing cycles plus the current one.
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   localparam logic [7:0] AddrSw     = 8'h00;
   localparam logic [7:0] AddrStable = 8'h10;
   localparam logic [7:0] AddrPend   = 8'h14;
   localparam logic [7:0] AddrMask   = 8'h18;
   localparam logic [7:0] AddrRel    = 8'h1C;

   // ---------------------------------------------------------------------------
   // Two-flop synchronizers
   // ---------------------------------------------------------------------------
   logic [31:0]     sw_sync1_q, sw_sync2_q;
   logic [NBTN-1:0] btn_sync1_q, btn_sync2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_sync1_q  <= '0;
         sw_sync2_q  <= '0;
         btn_sync1_q <= '0;
         btn_sync2_q <= '0;
      end else begin
         sw_sync1_q  <= io_sw;
         sw_sync2_q  <= sw_sync1_q;
         btn_sync1_q <= io_btn;
         btn_sync2_q <= btn_sync1_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Per-button debounce
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q [NBTN];
   logic [CNT_W-1:0] cnt_d [NBTN];
   logic [NBTN-1:0]  stable_q, stable_d;
   logic [NBTN-1:0]  rise, fall;

   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NBTN; i++) begin
         cnt_d[i] = cnt_q[i];
         if (btn_sync2_q[i] == stable_q[i]) begin
            // Agreement (including any glitch ending) restarts the count.
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntLast) begin
            stable_d[i] = btn_sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            // Bounded by the CntLast compare above, so this never wraps.
            cnt_d[i] = cnt_q[i] + CntOne;
         end
      end
   end

   // Edge events are taken from the stable transition itself so that the
   // event flop sets on the same edge the stable value updates.
   assign rise = stable_d & ~stable_q;
   assign fall = ~stable_d & stable_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stable_q <= '0;
         for (int i = 0; i < NBTN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         stable_q <= stable_d;
         for (int i = 0; i < NBTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Write decode
   // ---------------------------------------------------------------------------
   logic            wr_pend, wr_mask;
   logic [NBTN-1:0] pend_clr;

   assign wr_pend  = we && (addr == AddrPend);
   assign wr_mask  = we && (addr == AddrMask);
   assign pend_clr = wr_pend ? wdata[NBTN-1:0] : '0;

   // Only the low nibble of wdata reaches any register.
   logic unused_wdata;
   assign unused_wdata = ^wdata[31:NBTN];

   // ---------------------------------------------------------------------------
   // Event, mask and interrupt registers
   // ---------------------------------------------------------------------------
   logic [NBTN-1:0] pend_q, pend_d;
   logic [NBTN-1:0] mask_q, mask_d;
   logic [NBTN-1:0] irq_src;
   logic            irq_q, irq_d;

   // Set wins over a simultaneous W1C of the same bit.
   assign pend_d = (pend_q & ~pend_clr) | rise;
   assign mask_d = wr_mask ? wdata[NBTN-1:0] : mask_q;

`ifdef INPUT_RELEASE_EVENT_EN
   logic            wr_rel;
   logic [NBTN-1:0] rel_clr;
   logic [NBTN-1:0] rel_q, rel_d;

   assign wr_rel  = we && (addr == AddrRel);
   assign rel_clr = wr_rel ? wdata[NBTN-1:0] : '0;
   assign rel_d   = (rel_q & ~rel_clr) | fall;

   always_ff @(posedge clk) begin
      if (rst) begin
         rel_q <= '0;
      end else begin
         rel_q <= rel_d;
      end
   end

   assign irq_src = (pend_q | rel_q) & mask_q;
`else
   // Release events are not tracked in this build.
   logic unused_fall;
   assign unused_fall = ^fall;

   assign irq_src = pend_q & mask_q;
`endif

   // irq registers the current masked event state, so it trails the event
   // flop by one edge on both assertion and clear.
   assign irq_d = |irq_src;

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         mask_q <= mask_d;
         irq_q  <= irq_d;
      end
   end

   assign irq = irq_q;

   // ---------------------------------------------------------------------------
   // Combinational read mux
   // ---------------------------------------------------------------------------
   always_comb begin
      rdata = 32'h0;
      case (addr)
         AddrSw:     rdata = sw_sync2_q;
         AddrStable: rdata = {28'h0, stable_q};
         AddrPend:   rdata = {28'h0, pend_q};
         AddrMask:   rdata = {28'h0, mask_q};
`ifdef INPUT_RELEASE_EVENT_EN
         AddrRel:    rdata = {28'h0, rel_q};
`endif
         default:    rdata = 32'h0;
      endcase
   end

endmodule
